commit_stream_checker: RTL
==========================

Name: commit_stream_checker

Overview:
- Downstream consumer of the pipelined CPU's writeback stage and of the reference model's writeback stage.
- Captures each retired write-back (PC, destination register, write data, halt flag) from both streams into per-stream FIFOs.
- Pairs DUT and model commits in program order and compares them, tolerating bounded timing skew between the two.
- Reports the first or every mismatch, counts commits, and signals completion when both streams retire HLT.

Parameters:
DEPTH, 8, entries per commit FIFO (power of two, >= 2)
SKEW_MAX, 16, max cycles one FIFO may be non-empty while the other is empty before a skew error
STOP_ON_ERR, 1, 1 = freeze in ERROR on first mismatch; 0 = log and keep comparing

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
dut_valid  in  1  DUT commit strobe (MEM_WB RegWrite or HLT)
dut_pc  in  16  DUT commit PC
dut_rd  in  4  DUT destination register
dut_wdata  in  16  DUT register write data
dut_hlt  in  1  DUT commit is HLT
mdl_valid  in  1  model commit strobe
mdl_pc  in  16  model commit PC
mdl_rd  in  4  model destination register
mdl_wdata  in  16  model register write data
mdl_hlt  in  1  model commit is HLT
mismatch  out  1  one-cycle pulse on failed compare
err_code  out  3  cause of last error: 0 none, 1 pc, 2 rd, 3 data, 4 hlt, 5 skew, 6 overflow
err_pc  out  16  DUT PC of the last failing pair (0 for skew or overflow)
commit_count  out  16  number of compared pairs, wraps at 0xFFFF -> 0
done  out  1  sticky; both streams retired HLT and matched
error  out  1  sticky; any error seen

Behaviour:
- Reset: the synchronous rst at posedge clk clears both FIFOs, the skew counter, and the state (-> RUN).
  - Reset values: mismatch=0, err_code=0, err_pc=0, commit_count=0, done=0, error=0.
  - A reset mid-run discards all queued entries; a push arriving in the reset cycle is dropped.
- Push: at each posedge in RUN, a valid stream writes its entry into its own FIFO.
  - Both streams may push in the same cycle.
  - Pushes are ignored in DONE and ERROR.
- Pop/compare: when both FIFOs are non-empty in RUN, the heads are popped at the same edge and compared.
  - Outputs update at that same edge, so a pair pushed at edge t can be compared at edge t+1 at the earliest.
  - Throughput is 1 pair per cycle.
- Compare priority: hlt differs -> 4; else pc differs -> 1; else rd differs -> 2; else wdata differs -> 3.
  - On any difference: mismatch=1 for one cycle, err_code and err_pc latched, error=1.
  - commit_count increments on every compared pair, pass or fail.
- Full FIFO: push into a full FIFO while it is popped in the same cycle is legal and loses nothing.
  - Push into a full FIFO with no pop drops the entry, sets err_code=6, error=1, and enters ERROR regardless of STOP_ON_ERR.
- Skew: the counter increments each cycle exactly one FIFO is non-empty and clears otherwise.
  - Reaching SKEW_MAX sets err_code=5, error=1 -> ERROR.
- State machine: RUN, DONE, ERROR.
  - RUN -> DONE when a compared pair has both hlt=1 and no mismatch; done=1.
  - RUN -> ERROR on overflow, on skew, or on any mismatch when STOP_ON_ERR=1.
  - With STOP_ON_ERR=0 a compare mismatch stays in RUN, and later mismatches overwrite err_code/err_pc.
  - A hlt-vs-hlt pair with a pc mismatch reports code 1 and goes to ERROR (when STOP_ON_ERR=1), not DONE.
  - DONE and ERROR are terminal until rst.
- Empty FIFOs: no compare, mismatch=0.

Decomposition:
- Package commit_check_pkg holds:
  - struct commit_t {pc[15:0], rd[3:0], wdata[15:0], hlt};
  - enum state_t {RUN, DONE, ERROR};
  - err_code localparams (ERR_NONE through ERR_OVF).
- Sub-module commit_fifo: a DEPTH x commit_t synchronous FIFO with push, pop, full, empty, and head output.
  - Pointers are log2(DEPTH)+1 bits wide, with wrap detection on the MSB.
  - It is instantiated twice; the top level holds the compare, skew counter, FSM, and output registers.

Test Plan:
- Lockstep match: 5 identical commits, e.g. PC 0x0000..0x0008 writing R1..R5, then HLT on both streams at the same cycle -> commit_count=6, done=1, error=0, mismatch never asserted.
- Data mismatch: the third commit has dut_wdata=0x1234, mdl_wdata=0x1235 -> mismatch pulse on the compare edge, err_code=3, err_pc=that PC, error=1, state ERROR, later commits ignored.
- Skew tolerance: the model stream is delayed 5 cycles relative to the DUT for 8 commits -> no error, commit_count=8. Delaying the model by 16 cycles with no model push -> err_code=5 on the 16th cycle.
- Overflow: DUT pushes 9 commits while the model is silent (DEPTH=8, SKEW_MAX=64) -> err_code=6, error=1 at the ninth push. Separately, a full FIFO pushed and popped in the same cycle -> no error.
- STOP_ON_ERR=0: rd mismatch at commit 2 and pc mismatch at commit 4 -> two mismatch pulses, final err_code=1, comparison continues to HLT, done=1, error=1.
- Reset mid-run: assert rst while 3 entries are queued -> next cycle all outputs are 0 and FIFOs are empty; a fresh matched sequence then passes.

Source files
------------

// File: rtl/commit_stream_checker_pkg.sv
// Shared types for the commit stream checker: commit record, checker state, error codes
// and the field-priority compare used to classify a DUT/model pair.
package commit_check_pkg;

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  rd;
        logic [15:0] wdata;
        logic        hlt;
    } commit_t;

    typedef enum logic [1:0] {
        RUN,
        DONE,
        ERROR
    } state_t;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_PC   = 3'd1;
    localparam logic [2:0] ERR_RD   = 3'd2;
    localparam logic [2:0] ERR_DATA = 3'd3;
    localparam logic [2:0] ERR_HLT  = 3'd4;
    localparam logic [2:0] ERR_SKEW = 3'd5;
    localparam logic [2:0] ERR_OVF  = 3'd6;

    // A halt disagreement outranks everything, so a runaway core is reported as such.
    function automatic logic [2:0] compare_commit(input commit_t d, input commit_t m);
        logic [2:0] code;
        if (d.hlt != m.hlt)
            code = ERR_HLT;
        else if (d.pc != m.pc)
            code = ERR_PC;
        else if (d.rd != m.rd)
            code = ERR_RD;
        else if (d.wdata != m.wdata)
            code = ERR_DATA;
        else
            code = ERR_NONE;
        return code;
    endfunction

endpackage

// File: rtl/commit_stream_checker_fifo.sv
// Synchronous DEPTH-entry FIFO of commit records with a combinational head.
// A push into a full FIFO is accepted only when the head is popped at the same edge.
module commit_fifo
    import commit_check_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  commit_t data_i,
    input  logic    pop_i,
    output commit_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [AW:0] PTR_ONE = PW'(1);

    commit_t     mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign wr_d    = do_push ? wr_q + PTR_ONE : wr_q;
    assign rd_d    = do_pop  ? rd_q + PTR_ONE : rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/commit_stream_checker.sv
// Pairs DUT and reference-model writeback commits in program order, compares them,
// and tracks skew, overflow, commit count and HLT completion.
module commit_stream_checker
    import commit_check_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SKEW_MAX    = 16,
    parameter int STOP_ON_ERR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dut_valid,
    input  logic [15:0] dut_pc,
    input  logic [3:0]  dut_rd,
    input  logic [15:0] dut_wdata,
    input  logic        dut_hlt,
    input  logic        mdl_valid,
    input  logic [15:0] mdl_pc,
    input  logic [3:0]  mdl_rd,
    input  logic [15:0] mdl_wdata,
    input  logic        mdl_hlt,
    output logic        mismatch,
    output logic [2:0]  err_code,
    output logic [15:0] err_pc,
    output logic [15:0] commit_count,
    output logic        done,
    output logic        error
);

    localparam int SW = $clog2(SKEW_MAX + 1);
    localparam logic [SW-1:0] SKEW_LAST = SW'(SKEW_MAX - 1);

    state_t      state_q, state_d;
    commit_t     dut_in, mdl_in, dut_head, mdl_head;
    logic        dut_full, dut_empty, mdl_full, mdl_empty;
    logic        in_run, push_dut, push_mdl, pop;
    logic [2:0]  cmp_code;
    logic        cmp_fail, cmp_halt, one_ne, skew_hit, ovf;
    logic [SW-1:0] skew_q, skew_d;
    logic        mismatch_q, mismatch_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [15:0] err_pc_q, err_pc_d;
    logic [15:0] commit_count_q, commit_count_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    assign dut_in = '{pc: dut_pc, rd: dut_rd, wdata: dut_wdata, hlt: dut_hlt};
    assign mdl_in = '{pc: mdl_pc, rd: mdl_rd, wdata: mdl_wdata, hlt: mdl_hlt};

    commit_fifo #(.DEPTH(DEPTH)) u_dut_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_dut),
        .data_i  (dut_in),
        .pop_i   (pop),
        .head_o  (dut_head),
        .full_o  (dut_full),
        .empty_o (dut_empty)
    );

    commit_fifo #(.DEPTH(DEPTH)) u_mdl_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_mdl),
        .data_i  (mdl_in),
        .pop_i   (pop),
        .head_o  (mdl_head),
        .full_o  (mdl_full),
        .empty_o (mdl_empty)
    );

    assign cmp_code = compare_commit(dut_head, mdl_head);
    assign cmp_fail = pop && (cmp_code != ERR_NONE);
    assign cmp_halt = pop && (cmp_code == ERR_NONE) && dut_head.hlt && mdl_head.hlt;
    assign one_ne   = dut_empty ^ mdl_empty;
    assign skew_hit = in_run && one_ne && (skew_q == SKEW_LAST);
    // Overflow only when no pop frees a slot at the same edge.
    assign ovf      = in_run && !pop && ((dut_valid && dut_full) || (mdl_valid && mdl_full));
    assign skew_d   = (in_run && one_ne) ? skew_q + SW'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == RUN) begin
            if (ovf || skew_hit || (cmp_fail && (STOP_ON_ERR != 0)))
                state_d = ERROR;
            else if (cmp_halt)
                state_d = DONE;
        end
    end

    always_comb begin
        in_run   = (state_q == RUN);
        push_dut = in_run && dut_valid;
        push_mdl = in_run && mdl_valid;
        pop      = in_run && !dut_empty && !mdl_empty;
    end

    always_comb begin
        mismatch_d     = cmp_fail;
        err_code_d     = err_code_q;
        err_pc_d       = err_pc_q;
        error_d        = error_q;
        done_d         = done_q || cmp_halt;
        commit_count_d = pop ? commit_count_q + 16'd1 : commit_count_q;
        if (ovf) begin
            err_code_d = ERR_OVF;
            err_pc_d   = '0;
            error_d    = 1'b1;
        end else if (skew_hit) begin
            err_code_d = ERR_SKEW;
            err_pc_d   = '0;
            error_d    = 1'b1;
        end else if (cmp_fail) begin
            err_code_d = cmp_code;
            err_pc_d   = dut_head.pc;
            error_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skew_q         <= '0;
            mismatch_q     <= 1'b0;
            err_code_q     <= ERR_NONE;
            err_pc_q       <= '0;
            commit_count_q <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            skew_q         <= skew_d;
            mismatch_q     <= mismatch_d;
            err_code_q     <= err_code_d;
            err_pc_q       <= err_pc_d;
            commit_count_q <= commit_count_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign mismatch     = mismatch_q;
    assign err_code     = err_code_q;
    assign err_pc       = err_pc_q;
    assign commit_count = commit_count_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule
